ail_seq: RTL and testbench
==========================

# ail_seq

Parametrised sequential auto-index unit: successor to the combinational auto-index decoder. From a latched instruction it resolves the operand's effective address (EA): direct, indirect, post-increment or pre-decrement auto-index. It runs the memory read-modify-write of the pointer itself over a ready-handshaked bus. It sits between the instruction register/PC and the memory arbiter, and hands EA to the microcode sequencer.

## Interface
- `WIDTH`, 16, address/data width (≥12)
- `OPW`, 10, operand field width; page = upper `WIDTH-OPW` bits
- `INC_BASE`, 'h080, first page-zero address with post-increment
- `INC_LEN`, 'h040, number of post-increment locations
- `DEC_BASE`, 'h0C0, first page-zero address with pre-decrement
- `DEC_LEN`, 'h040, number of pre-decrement locations
- `STEP`, 1, increment/decrement amount (modulo 2^WIDTH)

- `clk` in 1: single clock; all state changes on rising edge
- `nreset` in 1: reset, synchronous, active-low
- `ir` in WIDTH: instruction; bit OPW+1 = I (indirect), bit OPW = R (local page), [OPW-1:0] = operand
- `pc` in WIDTH: program counter; supplies the local page
- `start` in 1: request resolution; sampled only in IDLE
- `busy` out 1: high in every state but IDLE
- `done` out 1: one-cycle pulse, EA valid
- `ea` out WIDTH: effective address; held until next accepted `start`
- `idx` out 2: mode of last request: 00 direct, 01 indirect, 10 post-inc, 11 pre-dec
- `mem_addr` out WIDTH, `mem_wdata` out WIDTH, `mem_rdata` in WIDTH
- `mem_rd` out 1, `mem_wr` out 1, `mem_ready` in 1

## Operation
- On accepted `start`, latch `ir` and `pc`. Base address A = {R ? pc page : 0, operand}.
- Mode: I=0 → direct. I=1,R=1 → indirect. I=1,R=0: A in [INC_BASE, INC_BASE+INC_LEN) → post-inc; A in [DEC_BASE, DEC_BASE+DEC_LEN) → pre-dec; otherwise indirect. If the ranges overlap, post-inc wins.
- States: IDLE, RD, WR, DONE.
  - IDLE: `start` → DONE for direct (ea=A); otherwise → RD.
  - RD: `mem_addr`=A, `mem_rd`=1. On edge with `mem_ready`=1, capture P=`mem_rdata`. Indirect → DONE, ea=P. Post-inc → WR, ea=P, wdata=P+STEP. Pre-dec → WR, ea=P−STEP, wdata=P−STEP.
  - WR: `mem_addr`=A, `mem_wr`=1, `mem_wdata` as above. On edge with `mem_ready`=1 → DONE.
  - DONE: `done`=1 for one cycle → IDLE.
- Pointer arithmetic wraps modulo 2^WIDTH: 'hFFFF+1='h0000, 'h0000−1='hFFFF.
- `mem_rd` and `mem_wr` are never high together. Both are low outside RD/WR.

## Timing
- Reset (`nreset`=0 at an edge) → IDLE. `busy`=0, `done`=0, `ea`=0, `idx`=00, `mem_rd`=0, `mem_wr`=0, `mem_addr`=0, `mem_wdata`=0.
- Reset mid-operation aborts at that edge. No write completes after the reset edge. Memory strobes drop in the same cycle.
- `start` while `busy` is ignored and is not queued. `start` in the DONE cycle is also ignored.
- `idx` updates at the accepting edge.
- Zero-wait latency (start edge → `done` high): direct 1 cycle, indirect 2, auto-index 3. Each `mem_ready`=0 cycle adds one.
- `mem_addr`, `mem_rd`/`mem_wr` and `mem_wdata` stay stable while waiting on `mem_ready`.
- `ea` changes only at the edge entering DONE. It is stable from there until the next accepted `start`.

## Test plan
- Reset: hold `nreset`=0 two cycles with `start`=1 → all outputs 0, `busy`=0. Release; no spurious `done`.
- Direct, local page: `pc`='h1234, `ir`={I=0,R=1,op='h055} → `done` 1 cycle after start, `ea`='h1055, `idx`=00, no memory strobe.
- Post-inc wrap: mem['h080]='hFFFF, `ir`={I=1,R=0,op='h080} → read 'h080, write 'h0000 to 'h080, `ea`='hFFFF, `idx`=10, `done` at +3.
- Pre-dec with waits: mem['h0C5]='h2000, `mem_ready` low 2 cycles in RD and 1 in WR → write 'h1FFF, `ea`='h1FFF, `idx`=11, `done` at +6, strobes stable throughout.
- Plain indirect: op='h07F (outside both ranges), mem='h4321 → `ea`='h4321, `idx`=01, no write. Second `start` while busy is ignored.
- Reset mid-WR: assert `nreset`=0 during WR with `mem_ready`=0 → `mem_wr` drops at that edge, IDLE, `done` never pulses.

Source files
------------

// File: rtl/ail_seq.sv
// Sequential auto-index unit: resolves a latched instruction's effective address and
// runs the pointer read-modify-write itself over a ready-handshaked memory bus.
module ail_seq #(
    parameter int WIDTH    = 16,
    parameter int OPW      = 10,
    parameter int INC_BASE = 'h080,
    parameter int INC_LEN  = 'h040,
    parameter int DEC_BASE = 'h0C0,
    parameter int DEC_LEN  = 'h040,
    parameter int STEP     = 1
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [WIDTH-1:0] ir,
    input  logic [WIDTH-1:0] pc,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] ea,
    output logic [1:0]       idx,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata,
    output logic             mem_rd,
    output logic             mem_wr,
    input  logic             mem_ready,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_DONE = 2'd3
    } state_t;

    localparam logic [1:0] M_DIRECT = 2'b00;
    localparam logic [1:0] M_IND    = 2'b01;
    localparam logic [1:0] M_POST   = 2'b10;
    localparam logic [1:0] M_PRE    = 2'b11;

    // One extra bit so a range ending exactly at 2^WIDTH still compares correctly.
    localparam logic [WIDTH:0]   INC_LO = (WIDTH+1)'(INC_BASE);
    localparam logic [WIDTH:0]   INC_HI = (WIDTH+1)'(INC_BASE + INC_LEN);
    localparam logic [WIDTH:0]   DEC_LO = (WIDTH+1)'(DEC_BASE);
    localparam logic [WIDTH:0]   DEC_HI = (WIDTH+1)'(DEC_BASE + DEC_LEN);
    localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

    state_t           state;
    logic [WIDTH-1:0] ea_pend;
    logic [WIDTH-1:0] a_next;
    logic [1:0]       mode_next;
    logic             in_inc;
    logic             in_dec;
    logic             unused_ok;

    assign unused_ok = &{1'b0, ir[WIDTH-1:OPW+2], pc[OPW-1:0]};
    assign dbg_state = state;

    always_comb begin
        a_next    = {(ir[OPW] ? pc[WIDTH-1:OPW] : {(WIDTH-OPW){1'b0}}), ir[OPW-1:0]};
        in_inc    = ({1'b0, a_next} >= INC_LO) && ({1'b0, a_next} < INC_HI);
        in_dec    = ({1'b0, a_next} >= DEC_LO) && ({1'b0, a_next} < DEC_HI);
        mode_next = M_DIRECT;
        if (ir[OPW+1]) begin
            if (ir[OPW])     mode_next = M_IND;
            else if (in_inc) mode_next = M_POST;
            else if (in_dec) mode_next = M_PRE;
            else             mode_next = M_IND;
        end
    end

    // mem_addr/mem_rd/mem_wr/mem_wdata only change on a ready edge, so they hold through waits.
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            done      <= 1'b0;
            ea        <= '0;
            ea_pend   <= '0;
            idx       <= M_DIRECT;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        idx  <= mode_next;
                        busy <= 1'b1;
                        if (mode_next == M_DIRECT) begin
                            ea    <= a_next;
                            done  <= 1'b1;
                            state <= S_DONE;
                        end else begin
                            mem_addr <= a_next;
                            mem_rd   <= 1'b1;
                            state    <= S_RD;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        mem_rd <= 1'b0;
                        case (idx)
                            M_POST: begin
                                ea_pend   <= mem_rdata;
                                mem_wdata <= mem_rdata + STEP_W;
                                mem_wr    <= 1'b1;
                                state     <= S_WR;
                            end
                            M_PRE: begin
                                ea_pend   <= mem_rdata - STEP_W;
                                mem_wdata <= mem_rdata - STEP_W;
                                mem_wr    <= 1'b1;
                                state     <= S_WR;
                            end
                            default: begin
                                ea       <= mem_rdata;
                                mem_addr <= '0;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end
                        endcase
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        mem_wr    <= 1'b0;
                        mem_addr  <= '0;
                        mem_wdata <= '0;
                        ea        <= ea_pend;
                        done      <= 1'b1;
                        state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy   <= 1'b0;
                    mem_rd <= 1'b0;
                    mem_wr <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ail_seq.sv
// Bench for ail_seq: directed scenarios plus randomized requests checked against
// an arithmetic reference model of address resolution and pointer update.
module tb_ail_seq;

    localparam int W   = 16;
    localparam int OPW = 10;

    logic          clk;
    logic          nreset;
    logic [W-1:0]  ir;
    logic [W-1:0]  pc;
    logic          start;
    logic          busy;
    logic          done;
    logic [W-1:0]  ea;
    logic [1:0]    idx;
    logic [W-1:0]  mem_addr;
    logic [W-1:0]  mem_wdata;
    logic [W-1:0]  mem_rdata;
    logic          mem_rd;
    logic          mem_wr;
    logic          mem_ready;
    logic [1:0]    dbg_state;

    logic [W-1:0]  mem     [0:65535];
    logic [W-1:0]  ref_mem [0:65535];

    int checks = 0;
    int errors = 0;
    logic [W-1:0] prev_ea;

    ail_seq dut (
        .clk       (clk),
        .nreset    (nreset),
        .ir        (ir),
        .pc        (pc),
        .start     (start),
        .busy      (busy),
        .done      (done),
        .ea        (ea),
        .idx       (idx),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_ready (mem_ready),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (nreset && mem_wr && mem_ready) mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: effective address and mode from the instruction fields, plain arithmetic.
    function automatic void model(input logic [W-1:0] t_ir, input logic [W-1:0] t_pc,
                                  output int a, output int mode);
        int op;
        int page;
        op   = int'(t_ir) % (2**OPW);
        page = t_ir[OPW] ? int'(t_pc) / (2**OPW) : 0;
        a    = page * (2**OPW) + op;
        if (!t_ir[OPW+1])                mode = 0;
        else if (t_ir[OPW])              mode = 1;
        else if (a >= 'h080 && a < 'h0C0) mode = 2;
        else if (a >= 'h0C0 && a < 'h100) mode = 3;
        else                             mode = 1;
    endfunction

    task automatic run_req(input logic [W-1:0] t_ir, input logic [W-1:0] t_pc,
                           input int rdw, input int wrw, input bit poke);
        int a, mode, p, exp_ea, exp_wv, exp_lat, cyc, rd_cnt, wr_cnt, writes, rd_any;
        bit seen_done;
        model(t_ir, t_pc, a, mode);
        p      = int'(ref_mem[a]);
        exp_wv = 0;
        case (mode)
            0: begin exp_ea = a; exp_lat = 1; end
            1: begin exp_ea = p; exp_lat = 2 + rdw; end
            2: begin exp_ea = p; exp_wv = (p + 1) % 65536; exp_lat = 3 + rdw + wrw; end
            default: begin exp_ea = (p + 65535) % 65536; exp_wv = exp_ea; exp_lat = 3 + rdw + wrw; end
        endcase
        @(negedge clk);
        ir = t_ir; pc = t_pc; start = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1;
        if (!poke) start = 1'b0;
        ir = W'($urandom); pc = W'($urandom);
        cyc = 0; rd_cnt = 0; wr_cnt = 0; writes = 0; rd_any = 0; seen_done = 0;
        while (!seen_done && cyc < 40) begin
            @(negedge clk);
            cyc++;
            chk("strobe_overlap", {31'd0, mem_rd & mem_wr}, 0);
            if (cyc == 1) chk("idx_at_accept", idx, mode);
            if (done) seen_done = 1;
            else begin
                chk("ea_hold", ea, prev_ea);
                chk("busy_active", busy, 1);
            end
            mem_ready = 1'b0;
            if (mem_rd) begin
                rd_any = 1;
                chk("rd_addr", mem_addr, a);
                if (rd_cnt >= rdw) mem_ready = 1'b1; else rd_cnt++;
            end else if (mem_wr) begin
                chk("wr_addr", mem_addr, a);
                chk("wr_data", mem_wdata, exp_wv);
                if (wr_cnt >= wrw) begin mem_ready = 1'b1; writes++; end
                else wr_cnt++;
            end
        end
        chk("done_seen", {31'd0, seen_done}, 1);
        chk("latency", cyc, exp_lat);
        chk("ea", ea, exp_ea);
        chk("idx", idx, mode);
        chk("busy_in_done", busy, 1);
        chk("read_used", rd_any, (mode != 0) ? 1 : 0);
        chk("write_count", writes, (mode >= 2) ? 1 : 0);
        if (mode >= 2) ref_mem[a] = W'(exp_wv);
        mem_ready = 1'b0;
        @(negedge clk);
        chk("done_pulse", {31'd0, done}, 0);
        chk("busy_idle", {31'd0, busy}, 0);
        chk("strobes_idle", {30'd0, mem_rd, mem_wr}, 0);
        start = 1'b0;
        @(negedge clk);
        chk("no_restart_done", {31'd0, done}, 0);
        chk("no_restart_busy", {31'd0, busy}, 0);
        chk("mem_state", mem[a], ref_mem[a]);
        chk("ea_stable", ea, exp_ea);
        prev_ea = W'(exp_ea);
    endtask

    task automatic set_mem(input int a, input logic [W-1:0] v);
        mem[a] = v;
        ref_mem[a] = v;
    endtask

    initial begin
        int sel, op, a, mode;
        logic [W-1:0] t_ir, t_pc, v;
        logic [W-1:0] ops [6];
        ops[0] = 'h07F; ops[1] = 'h080; ops[2] = 'h0BF;
        ops[3] = 'h0C0; ops[4] = 'h0FF; ops[5] = 'h100;

        nreset = 1'b0; start = 1'b1; ir = 'h0455; pc = 'h1234; mem_ready = 1'b0;
        prev_ea = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", {31'd0, busy}, 0);
        chk("rst_done", {31'd0, done}, 0);
        chk("rst_ea", ea, 0);
        chk("rst_idx", idx, 0);
        chk("rst_rd", {31'd0, mem_rd}, 0);
        chk("rst_wr", {31'd0, mem_wr}, 0);
        chk("rst_addr", mem_addr, 0);
        chk("rst_wdata", mem_wdata, 0);
        nreset = 1'b1; start = 1'b0;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", {31'd0, done}, 0);
            chk("post_rst_busy", {31'd0, busy}, 0);
        end

        // Directed scenarios.
        run_req(16'h0455, 16'h1234, 0, 0, 0);
        set_mem('h080, 16'hFFFF);
        run_req(16'h0880, 16'h0000, 0, 0, 0);
        set_mem('h0C5, 16'h2000);
        run_req(16'h08C5, 16'hABCD, 2, 1, 0);
        set_mem('h07F, 16'h4321);
        run_req(16'h087F, 16'h5555, 0, 0, 1);
        set_mem('h0C0, 16'h0000);
        run_req(16'h08C0, 16'h0000, 1, 2, 0);

        // Reset during a stalled write aborts it.
        set_mem('h081, 16'h1234);
        @(negedge clk);
        ir = 16'h0881; pc = 16'h0000; start = 1'b1; mem_ready = 1'b0;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        chk("mr_rd", {31'd0, mem_rd}, 1);
        mem_ready = 1'b1;
        @(negedge clk);
        chk("mr_wr", {31'd0, mem_wr}, 1);
        mem_ready = 1'b0; nreset = 1'b0;
        @(negedge clk);
        chk("mr_wr_drop", {31'd0, mem_wr}, 0);
        chk("mr_rd_low", {31'd0, mem_rd}, 0);
        chk("mr_busy", {31'd0, busy}, 0);
        chk("mr_done", {31'd0, done}, 0);
        chk("mr_ea", ea, 0);
        chk("mr_mem", mem['h081], 16'h1234);
        nreset = 1'b1;
        prev_ea = '0;
        repeat (4) begin
            @(negedge clk);
            chk("mr_no_done", {31'd0, done}, 0);
            chk("mr_idle", {31'd0, busy}, 0);
        end

        // Randomized requests.
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 3);
            case (sel)
                0: op = 'h080 + $urandom_range(0, 63);
                1: op = 'h0C0 + $urandom_range(0, 63);
                2: op = $urandom_range(0, 1023);
                default: op = int'(ops[$urandom_range(0, 5)]);
            endcase
            t_ir = W'($urandom);
            t_ir[OPW-1:0] = op[OPW-1:0];
            t_pc = W'($urandom);
            model(t_ir, t_pc, a, mode);
            case ($urandom_range(0, 3))
                0: v = 16'hFFFF;
                1: v = 16'h0000;
                default: v = W'($urandom);
            endcase
            set_mem(a, v);
            run_req(t_ir, t_pc, $urandom_range(0, 2), $urandom_range(0, 2), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
